bullet_stepper: RTL
===================

// Module: bullet_stepper
// PURPOSE
//  Consumes the slow bullet clock produced by the bullet clock divider and moves one bullet
//  across the playfield on each rising edge of that clock.
//  The divided clock is treated as a data level in the clk_in domain, never as a clock.
//  A fire request loads a start position and one of 8 directions. The block steps until the
//  bullet leaves the field or is hit, then retires with a one-cycle done pulse.
//  One instance per bullet; the VGA renderer reads bullet_x/bullet_y.
// PARAMETERS
//  X_MAX    640  playfield width; legal x is 0..X_MAX-1
//  Y_MAX    480  playfield height; legal y is 0..Y_MAX-1
//  COORD_W  10   width of the coordinate ports
//  STEP     4    pixels moved per axis per step (same on diagonals)
// PORTS
//  clk_in    in   1        system clock; sole clock
//  reset     in   1        synchronous, active-high reset
//  tick_in   in   1        divided bullet clock level from the divider, in clk_in domain
//  fire      in   1        spawn request, sampled only in IDLE
//  fire_x    in   COORD_W  spawn x
//  fire_y    in   COORD_W  spawn y
//  fire_dir  in   3        0=E 1=NE 2=N 3=NW 4=W 5=SW 6=S 7=SE (N = -y)
//  hit       in   1        collision; kills the bullet in FLY
//  active    out  1        1 while in FLY
//  bullet_x  out  COORD_W  current x
//  bullet_y  out  COORD_W  current y
//  done      out  1        one-cycle pulse on retirement
// BEHAVIOUR
//  - One clock (clk_in). Reset is synchronous and active-high.
//  - Reset: state=IDLE, active=0, done=0, bullet_x=0, bullet_y=0, tick_prev=1.
//    tick_prev resets to 1 so a high tick_in at reset release does not cause a step.
//  - Edge detect: step_en = tick_in & ~tick_prev; tick_prev <= tick_in every cycle.
//    Only rising edges step, i.e. once per full divided-clock period.
//  - FSM states: IDLE, FLY, DONE.
//  - IDLE: fire=1 loads fire_x/fire_y/fire_dir and moves to FLY; active=1 the next cycle.
//    step_en in the load cycle is ignored. Positions hold their last value in IDLE.
//  - FLY, with priority hit > step_en:
//    - hit=1: go to DONE; position is not updated.
//    - step_en=1: compute nx = x + dx*STEP and ny = y + dy*STEP, with dx,dy in {-1,0,+1}.
//      Arithmetic is signed, COORD_W+2 bits wide.
//      If nx<0, nx>=X_MAX, ny<0 or ny>=Y_MAX: go to DONE; position holds its last legal value.
//      Otherwise load nx/ny; the new value is visible the cycle after the edge cycle.
//  - FLY: fire is ignored (no queueing).
//  - DONE: done=1 and active=0 for exactly one cycle, then IDLE. fire in DONE is ignored.
//  - Reset asserted mid-flight: FLY→IDLE next edge, no done pulse.
// CONFIGURATION
//  BULLET_WRAP_EN (defined): the field edge does not retire the bullet; each axis wraps instead.
//    - Below 0: add X_MAX (or Y_MAX).
//    - At or above the limit: subtract X_MAX (or Y_MAX).
//    - Only hit leads to DONE.
//  Undefined: edge crossing retires the bullet as described above.
// TESTING (STEP=4, X_MAX=640, Y_MAX=480)
//  1. fire (100,100) dir0, then 3 tick rising edges -> bullet_x=112, bullet_y=100, active=1.
//  2. fire (50,2) dir2, one edge -> done pulses 1 cycle, active=0, bullet_y stays 2.
//  3. In FLY, hit and step_en in the same cycle -> done pulses; position unchanged.
//  4. fire during FLY with fire_x=300 -> ignored; bullet_x continues its own path.
//     tick_in held high for 10 cycles -> exactly one step.
//  5. reset mid-flight -> next cycle active=0, bullet_x=bullet_y=0, done never asserted.
//  6. BULLET_WRAP_EN: fire (638,10) dir0, one edge -> bullet_x=2, active=1.
//     Without the macro: done pulses and bullet_x stays 638.

Source files
------------

// File: rtl/bullet_stepper.sv
// rtl/bullet_stepper.sv - moves one bullet per rising edge of the divided bullet clock level.
// Optional BULLET_WRAP_EN: playfield edges wrap each axis instead of retiring the bullet.
module bullet_stepper #(
  parameter int X_MAX   = 640,
  parameter int Y_MAX   = 480,
  parameter int COORD_W = 10,
  parameter int STEP    = 4
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic               tick_in,
  input  logic               fire,
  input  logic [COORD_W-1:0] fire_x,
  input  logic [COORD_W-1:0] fire_y,
  input  logic [2:0]         fire_dir,
  input  logic               hit,
  output logic               active,
  output logic [COORD_W-1:0] bullet_x,
  output logic [COORD_W-1:0] bullet_y,
  output logic               done
);

  localparam int SW = COORD_W + 2;
  localparam logic signed [SW-1:0] STEP_P = SW'(STEP);
  localparam logic signed [SW-1:0] STEP_N = -STEP_P;
  localparam logic signed [SW-1:0] X_LIM  = SW'(X_MAX);
  localparam logic signed [SW-1:0] Y_LIM  = SW'(Y_MAX);

  typedef enum logic [1:0] {IDLE, FLY, DONE} state_t;

  state_t               state, state_next;
  logic [COORD_W-1:0]   bx, by, x_next, y_next;
  logic [2:0]           dir, dir_next;
  logic                 tick_prev;
  logic                 step_en;
  logic signed [SW-1:0] dx_s, dy_s, nx, ny, nx_fit, ny_fit;
  logic                 x_low, x_high, y_low, y_high, out_of_field;

  // The divided clock is only ever sampled as data; a step fires on its rising edge.
  assign step_en = tick_in & ~tick_prev;

  always_comb begin
    dx_s = '0;
    dy_s = '0;
    case (dir)
      3'd0: begin dx_s = STEP_P; dy_s = '0;     end
      3'd1: begin dx_s = STEP_P; dy_s = STEP_N; end
      3'd2: begin dx_s = '0;     dy_s = STEP_N; end
      3'd3: begin dx_s = STEP_N; dy_s = STEP_N; end
      3'd4: begin dx_s = STEP_N; dy_s = '0;     end
      3'd5: begin dx_s = STEP_N; dy_s = STEP_P; end
      3'd6: begin dx_s = '0;     dy_s = STEP_P; end
      default: begin dx_s = STEP_P; dy_s = STEP_P; end
    endcase
  end

  assign nx     = $signed({2'b00, bx}) + dx_s;
  assign ny     = $signed({2'b00, by}) + dy_s;
  assign x_low  = nx < 0;
  assign x_high = nx >= X_LIM;
  assign y_low  = ny < 0;
  assign y_high = ny >= Y_LIM;

`ifdef BULLET_WRAP_EN
  assign nx_fit       = x_low ? nx + X_LIM : (x_high ? nx - X_LIM : nx);
  assign ny_fit       = y_low ? ny + Y_LIM : (y_high ? ny - Y_LIM : ny);
  assign out_of_field = 1'b0;
`else
  assign nx_fit       = nx;
  assign ny_fit       = ny;
  assign out_of_field = x_low | x_high | y_low | y_high;
`endif

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state     <= IDLE;
      bx        <= '0;
      by        <= '0;
      dir       <= '0;
      tick_prev <= 1'b1;
    end else begin
      state     <= state_next;
      bx        <= x_next;
      by        <= y_next;
      dir       <= dir_next;
      tick_prev <= tick_in;
    end
  end

  always_comb begin
    state_next = state;
    x_next     = bx;
    y_next     = by;
    dir_next   = dir;
    case (state)
      IDLE: begin
        if (fire) begin
          x_next     = fire_x;
          y_next     = fire_y;
          dir_next   = fire_dir;
          state_next = FLY;
        end
      end
      FLY: begin
        if (hit) begin
          state_next = DONE;
        end else if (step_en) begin
          if (out_of_field) begin
            state_next = DONE;
          end else begin
            x_next = nx_fit[COORD_W-1:0];
            y_next = ny_fit[COORD_W-1:0];
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign active   = (state == FLY);
  assign done     = (state == DONE);
  assign bullet_x = bx;
  assign bullet_y = by;

endmodule
